// File: rtl/seg7_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg7_ctrl_pkg
// Shared types and constants for the six-digit seven-segment sequencing
// controller.
//   mode_e   : load mode code carried on the load bus (2 bits)
//   state_e  : controller FSM state
//   helpers  : mode-to-state mapping and one-digit left rotations
// -----------------------------------------------------------------------------
package seg7_ctrl_pkg;

    localparam int          NUM_DIGITS = 6;
    localparam int          DIG_W      = 4 * NUM_DIGITS;
    localparam logic [5:0]  BLANK_ALL  = 6'h3F;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_SCROLL = 2'd1,
        ST_BLINK  = 2'd2
    } state_e;

    // The reserved code is deliberately folded onto the static behaviour.
    function automatic state_e mode_to_state(input mode_e m);
        state_e s;
        case (m)
            MODE_SCROLL: s = ST_SCROLL;
            MODE_BLINK:  s = ST_BLINK;
            default:     s = ST_STATIC;
        endcase
        return s;
    endfunction

    // Rotate the digit nibbles left by one digit: the top digit wraps to HEX0.
    function automatic logic [DIG_W-1:0] rotl_digits(input logic [DIG_W-1:0] d);
        return {d[DIG_W-5:0], d[DIG_W-1:DIG_W-4]};
    endfunction

    // Rotate the blank mask in step with the digits.
    function automatic logic [NUM_DIGITS-1:0] rotl_blank(input logic [NUM_DIGITS-1:0] b);
        return {b[NUM_DIGITS-2:0], b[NUM_DIGITS-1]};
    endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl_if
// Load bus for the seven-segment controller (valid/ready handshake).
//   load_valid  master -> slave  load request
//   load_ready  slave  -> master controller can accept a load
//   load_data   master -> slave  24-bit value, digit i = [4i+3:4i]
//   load_mode   master -> slave  0 static, 1 scroll, 2 blink, 3 reserved
//   load_blank  master -> slave  per-digit blank mask
// -----------------------------------------------------------------------------
interface seg7_display_ctrl_if;

    logic        load_valid;
    logic        load_ready;
    logic [23:0] load_data;
    logic [1:0]  load_mode;
    logic [5:0]  load_blank;

    modport master (
        output load_valid,
        output load_data,
        output load_mode,
        output load_blank,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_mode,
        input  load_blank,
        output load_ready
    );

endinterface

// File: rtl/seg7_tick_gen.sv
// -----------------------------------------------------------------------------
// seg7_tick_gen
// Free-running prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ
// cycles. A synchronous restart forces the count back to zero so the next
// tick lands exactly TICK_DIV cycles after the restart edge.
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   restart_i  synchronous restart of the count (wins over the wrap)
//   tick_o     high while the count equals TICK_DIV-1
// TICK_DIV = CLK_HZ/TICK_HZ must be at least 2.
// -----------------------------------------------------------------------------
module seg7_tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick_o = (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (restart_i || tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl
// Sequencing controller for the six-digit DE10-Lite seven-segment display.
// Accepts a value on the load bus and presents it to the external LUT
// decoder as static, a one-shot six-step scroll, or blinking.
//   MAX10_CLK1_50  clock, rising edge
//   reset_n        asynchronous active-low reset
//   load_if        load bus (slave side)
//   dig_out        24 bits of digit nibbles to the decoder
//   blank_out      per-digit blank (1 = digit dark)
//   busy           high while a scroll is in progress
//   tick           prescaler pulse, exported for debug
// -----------------------------------------------------------------------------
module seg7_display_ctrl
    import seg7_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 4
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     reset_n,
    seg7_display_ctrl_if.slave       load_if,
    output logic [DIG_W-1:0]         dig_out,
    output logic [NUM_DIGITS-1:0]    blank_out,
    output logic                     busy,
    output logic                     tick
);

    localparam logic PHASE_ON = 1'b1;

    state_e                  state_q, state_d;
    logic [DIG_W-1:0]        dig_q,   dig_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   base_q,  base_d;    // mask restored in blink ON phase
    logic [2:0]              step_q,  step_d;    // scroll rotations applied so far
    logic                    phase_q, phase_d;   // blink phase, 1 = ON

    logic ready_w;
    logic accept_w;
    logic tick_w;

    assign ready_w          = (state_q != ST_SCROLL);
    assign accept_w         = load_if.load_valid && ready_w;
    assign load_if.load_ready = ready_w;

    // An accepted load restarts the prescaler, so a tick in the same cycle
    // is simply dropped along with whatever it would have done.
    seg7_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk_i     (MAX10_CLK1_50),
        .rst_ni    (reset_n),
        .restart_i (accept_w),
        .tick_o    (tick_w)
    );

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        blank_d = blank_q;
        base_d  = base_q;
        step_d  = step_q;
        phase_d = phase_q;

        if (accept_w) begin
            dig_d   = load_if.load_data;
            blank_d = load_if.load_blank;
            base_d  = load_if.load_blank;
            step_d  = 3'd0;
            phase_d = PHASE_ON;
            state_d = mode_to_state(mode_e'(load_if.load_mode));
        end else if (tick_w) begin
            case (state_q)
                ST_SCROLL: begin
                    dig_d   = rotl_digits(dig_q);
                    blank_d = rotl_blank(blank_q);
                    // Six rotations bring the value back to where it started.
                    if (step_q == 3'(NUM_DIGITS - 1)) begin
                        step_d  = 3'd0;
                        state_d = ST_STATIC;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
                ST_BLINK: begin
                    phase_d = ~phase_q;
                    // Leaving ON goes fully dark; returning to ON restores the mask.
                    blank_d = (phase_q == PHASE_ON) ? BLANK_ALL : base_q;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STATIC;
            dig_q   <= '0;
            blank_q <= BLANK_ALL;
            base_q  <= BLANK_ALL;
            step_q  <= 3'd0;
            phase_q <= PHASE_ON;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            base_q  <= base_d;
            step_q  <= step_d;
            phase_q <= phase_d;
        end
    end

    assign dig_out   = dig_q;
    assign blank_out = blank_q;
    assign busy      = (state_q == ST_SCROLL);
    assign tick      = tick_w;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_ctrl
// Directed bench for seg7_display_ctrl at CLK_HZ=100, TICK_HZ=10 (TICK_DIV=10).
// Stimulus schedules expected observations, keyed by clock-edge count, into a
// scoreboard queue; an independent monitor on the falling edge pops every
// entry that falls due and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_seg7_display_ctrl;

    typedef struct {
        int          cyc;
        string       name;
        logic [23:0] dig;
        logic [5:0]  blank;
        logic        rdy;
        logic        bsy;
        logic        chk_tick;
        logic        tck;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] dig_out;
    logic [5:0]  blank_out;
    logic        busy;
    logic        tick;

    seg7_display_ctrl_if lif();

    seg7_display_ctrl #(
        .CLK_HZ  (100),
        .TICK_HZ (10)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset_n       (reset_n),
        .load_if       (lif.slave),
        .dig_out       (dig_out),
        .blank_out     (blank_out),
        .busy          (busy),
        .tick          (tick)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    function automatic void push(int c, string nm, logic [23:0] d, logic [5:0] b,
                                 logic r, logic bs, logic ct, logic t);
        exp_t e;
        e.cyc = c; e.name = nm; e.dig = d; e.blank = b;
        e.rdy = r; e.bsy = bs; e.chk_tick = ct; e.tck = t;
        sb_q.push_back(e);
    endfunction

    // Monitor: compare every due scoreboard entry against the DUT.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_vec++;
            if (e.cyc != cyc || dig_out !== e.dig || blank_out !== e.blank ||
                lif.load_ready !== e.rdy || busy !== e.bsy ||
                (e.chk_tick && tick !== e.tck)) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got dig=%h blank=%h ready=%b busy=%b tick=%b; required dig=%h blank=%h ready=%b busy=%b tick=%b(chk=%b) at cyc %0d",
                         e.name, cyc, dig_out, blank_out, lif.load_ready, busy, tick,
                         e.dig, e.blank, e.rdy, e.bsy, e.tck, e.chk_tick, e.cyc);
            end else begin
                $display("ok   %s cyc=%0d dig=%h blank=%h ready=%b busy=%b tick=%b",
                         e.name, cyc, dig_out, blank_out, lif.load_ready, busy, tick);
            end
        end
    end

    task automatic wait_to(int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(logic v, logic [23:0] d, logic [1:0] m, logic [5:0] b);
        lif.load_valid = v;
        lif.load_data  = d;
        lif.load_mode  = m;
        lif.load_blank = b;
    endtask

    initial begin
        int a, b, c, d;
        logic [23:0] rot_d [6];
        logic [5:0]  rot_b [6];
        rot_d = '{24'h123456, 24'h234561, 24'h345612, 24'h456123, 24'h561234, 24'h612345};
        rot_b = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};

        // Reset and idle
        reset_n = 1'b0;
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        push(2, "reset", 24'h0, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_to(3);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++)
            push(5 + 10 * k, "idle", 24'h0, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_to(60);

        // Static load, stable for 100 cycles
        c = cyc;
        drive(1'b1, 24'h123456, 2'd0, 6'h00);
        a = c + 1;
        push(c,       "pre_static",  24'h0,      6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
        push(a,       "static_load", 24'h123456, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        push(a + 9,   "static_tick", 24'h123456, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        push(a + 50,  "static_50",   24'h123456, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        push(a + 100, "static_100",  24'h123456, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_to(a);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(a + 100);

        // Scroll, with a second load held valid throughout
        c = cyc;
        drive(1'b1, 24'h123456, 2'd1, 6'h01);
        a = c + 1;
        for (int k = 0; k < 6; k++) begin
            push(a + 10 * k,     "scroll_step", rot_d[k], rot_b[k], 1'b0, 1'b1, 1'b0, 1'b0);
            push(a + 10 * k + 9, "scroll_tick", rot_d[k], rot_b[k], 1'b0, 1'b1, 1'b1, 1'b1);
        end
        push(a + 60, "scroll_done", 24'h123456, 6'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        push(a + 61, "held_load",   24'h00BEEF, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_to(a);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(a + 20);
        drive(1'b1, 24'h00BEEF, 2'd0, 6'h00);
        wait_to(a + 61);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(a + 70);

        // Reserved mode acts as static
        c = cyc;
        drive(1'b1, 24'h13579B, 2'd3, 6'h05);
        a = c + 1;
        push(a,      "rsvd_load", 24'h13579B, 6'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        push(a + 15, "rsvd_15",   24'h13579B, 6'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        push(a + 25, "rsvd_25",   24'h13579B, 6'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_to(a);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(a + 30);

        // Blink, then a load coinciding with a tick
        c = cyc;
        drive(1'b1, 24'hABCDEF, 2'd2, 6'h01);
        b = c + 1;
        push(b,      "blink_on",    24'hABCDEF, 6'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        push(b + 9,  "blink_tick",  24'hABCDEF, 6'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        push(b + 10, "blink_off",   24'hABCDEF, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b0);
        push(b + 19, "blink_off_e", 24'hABCDEF, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
        push(b + 20, "blink_on2",   24'hABCDEF, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        push(b + 30, "blink_off2",  24'hABCDEF, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
        push(b + 39, "pre_coinc",   24'hABCDEF, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_to(b);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(b + 39);
        drive(1'b1, 24'h654321, 2'd2, 6'h02);
        c = b + 40;
        push(c,      "coinc_load",  24'h654321, 6'h02, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 8,  "coinc_8",     24'h654321, 6'h02, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 9,  "coinc_tick",  24'h654321, 6'h02, 1'b1, 1'b0, 1'b1, 1'b1);
        push(c + 10, "coinc_off",   24'h654321, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_to(c);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(c + 12);

        // Reset pulse during the third scroll step, then a fresh static load
        c = cyc;
        drive(1'b1, 24'h123456, 2'd1, 6'h00);
        d = c + 1;
        push(d + 10, "rs_step1",  24'h234561, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        push(d + 20, "rs_step2",  24'h345612, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        push(d + 25, "rst_async", 24'h0,      6'h3F, 1'b1, 1'b0, 1'b1, 1'b0);
        push(d + 27, "rst_hold",  24'h0,      6'h3F, 1'b1, 1'b0, 1'b1, 1'b0);
        push(d + 31, "post_rst",  24'h0F0F0F, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        push(d + 40, "post_rst9", 24'h0F0F0F, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_to(d);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(d + 25);
        reset_n = 1'b0;
        wait_to(d + 28);
        reset_n = 1'b1;
        wait_to(d + 30);
        drive(1'b1, 24'h0F0F0F, 2'd0, 6'h00);
        wait_to(d + 31);
        drive(1'b0, 24'h0, 2'd0, 6'h0);
        wait_to(d + 45);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            $display("FAIL drain: got %0d entries pending, required 0", sb_q.size());
            n_vec += sb_q.size();
            n_bad += sb_q.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, required completion");
        $fatal(1, "timeout");
    end

endmodule
